// File: rtl/ccd_pkg.sv
// Shared definitions for the linear-CCD frame timing path: state encoding and
// default timing constants so the ADC capture stage stays consistent.
package ccd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ICG_LEAD  = 3'd1,
    ST_SH_PULSE  = 3'd2,
    ST_ICG_TRAIL = 3'd3,
    ST_READOUT   = 3'd4,
    ST_DONE      = 3'd5
  } ccd_state_t;

  localparam int DEF_NUM_PIXELS   = 3694;
  localparam int DEF_FM_PER_PIX   = 4;
  localparam int DEF_SAMPLE_PHASE = 2;
  localparam int DEF_T_ICG_LEAD   = 25;
  localparam int DEF_T_SH         = 100;
  localparam int DEF_T_ICG_TRAIL  = 50;
  localparam int DEF_FM_TIMEOUT   = 100;
  localparam int DEF_PIX_W        = 12;

  function automatic int ccd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ccd_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// rising-edge pulse taken from the synchronised copy.
module ccd_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise_pulse
);

  // [0] first sync stage, [1] second sync stage, [2] previous synchronised value
  logic [2:0] pipe_q;
  logic [2:0] pipe_d;

  // shift the async level through the synchroniser chain
  always_comb begin
    pipe_d = {pipe_q[1:0], d_async};
  end

  // synchroniser and edge-history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= 3'b000;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign rise_pulse = pipe_q[1] & ~pipe_q[2];

endmodule

// File: rtl/ccd_frame_timing.sv
// Linear-CCD frame sequencer: ICG/SH transfer window with fixed clk_50m timing,
// then a ccd_master-paced readout issuing one ADC strobe per pixel.
module ccd_frame_timing
  import ccd_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int FM_PER_PIX   = DEF_FM_PER_PIX,
  parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE,
  parameter int T_ICG_LEAD   = DEF_T_ICG_LEAD,
  parameter int T_SH         = DEF_T_SH,
  parameter int T_ICG_TRAIL  = DEF_T_ICG_TRAIL,
  parameter int FM_TIMEOUT   = DEF_FM_TIMEOUT,
  parameter int PIX_W        = DEF_PIX_W
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             ccd_master,
  input  logic             start,
  input  logic             abort,
  output logic             ccd_sh,
  output logic             ccd_icg,
  output logic             adc_strobe,
  output logic [PIX_W-1:0] pixel_index,
  output logic             busy,
  output logic             frame_done,
  output logic             fm_err
);

  localparam int CNT_MAX = ccd_max(ccd_max(T_ICG_LEAD, T_SH), ccd_max(T_ICG_TRAIL, FM_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int PH_W    = $clog2(FM_PER_PIX) + 1;

  logic fm_tick;

  ccd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             sh_q, sh_d;
  logic             icg_q, icg_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  ccd_edge_sync u_fm_sync (
    .clk        (clk_50m),
    .rst        (rst),
    .d_async    (ccd_master),
    .rise_pulse (fm_tick)
  );

  // next-state, counters and next output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    pixel_d  = pixel_q;
    err_d    = err_q;
    strobe_d = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // abort also wins over a simultaneous start while idle
          if (start && !abort) begin
            state_d = ST_ICG_LEAD;
            cnt_d   = {CNT_W{1'b0}};
            err_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ICG_LEAD: begin
          if (cnt_q == CNT_W'(T_ICG_LEAD - 1)) begin
            state_d = ST_SH_PULSE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SH_PULSE: begin
          if (cnt_q == CNT_W'(T_SH - 1)) begin
            state_d = ST_ICG_TRAIL;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ICG_TRAIL: begin
          if (cnt_q == CNT_W'(T_ICG_TRAIL - 1)) begin
            state_d = ST_READOUT;
            cnt_d   = {CNT_W{1'b0}};
            phase_d = {PH_W{1'b0}};
            pixel_d = {PIX_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_READOUT: begin
          // cnt_q doubles as the ccd_master stall watchdog here
          if (fm_tick) begin
            cnt_d    = {CNT_W{1'b0}};
            strobe_d = (phase_q == PH_W'(SAMPLE_PHASE));
            if (phase_q == PH_W'(FM_PER_PIX - 1)) begin
              phase_d = {PH_W{1'b0}};
              if (pixel_q == PIX_W'(NUM_PIXELS - 1)) begin
                state_d = ST_DONE;
              end else begin
                pixel_d = pixel_q + PIX_W'(1);
              end
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end else if (cnt_q == CNT_W'(FM_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // outputs follow the state being entered so they stay aligned with it
    sh_d   = (state_d == ST_SH_PULSE);
    icg_d  = !((state_d == ST_ICG_LEAD) || (state_d == ST_SH_PULSE) || (state_d == ST_ICG_TRAIL));
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      phase_q  <= {PH_W{1'b0}};
      pixel_q  <= {PIX_W{1'b0}};
      sh_q     <= 1'b0;
      icg_q    <= 1'b1;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      pixel_q  <= pixel_d;
      sh_q     <= sh_d;
      icg_q    <= icg_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ccd_sh      = sh_q;
  assign ccd_icg     = icg_q;
  assign adc_strobe  = strobe_q;
  assign pixel_index = pixel_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign fm_err      = err_q;

endmodule
